// File: rtl/dut_bus_pkg.sv
// ============================================================================
//  dut_bus_pkg
//  Shared widths, idle command and arbiter state encoding for dut_bus_arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dut_bus_pkg;

  localparam int CMD_W  = 4;
  localparam int ADR_W  = 4;
  localparam int DATA_W = 4;

  localparam logic [CMD_W-1:0] IDLE_CMD = 4'h0;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dut_bus_arbiter_if.sv
// ============================================================================
//  dut_bus_arbiter_if
//  Requester-side inputs and registered bus outputs of the arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface dut_bus_arbiter_if
  import dut_bus_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ-1:0]         lock_i;
  logic [NUM_REQ*CMD_W-1:0]   cmd_i;
  logic [NUM_REQ*ADR_W-1:0]   adr_i;
  logic [NUM_REQ*DATA_W-1:0]  data_i;

  logic [NUM_REQ-1:0]         gnt_o;
  logic [$clog2(NUM_REQ)-1:0] owner_o;
  logic                       valid_o;
  logic [CMD_W-1:0]           cmd_o;
  logic [ADR_W-1:0]           adr_o;
  logic [DATA_W-1:0]          data_o;

  // Arbiter side
  modport master (
    input  req_i, lock_i, cmd_i, adr_i, data_i,
    output gnt_o, owner_o, valid_o, cmd_o, adr_o, data_o
  );

  // Requester / driver side
  modport slave (
    output req_i, lock_i, cmd_i, adr_i, data_i,
    input  gnt_o, owner_o, valid_o, cmd_o, adr_o, data_o
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  rr_pick
//  Combinational first-set search over req_i starting at start_i, wrapping.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = start_i;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
      cand = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dut_bus_arbiter.sv
// ============================================================================
//  dut_bus_arbiter
//  Round-robin arbiter with capped lock bursts driving one registered bus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dut_bus_arbiter
  import dut_bus_pkg::*;
#(
  parameter int               NUM_REQ   = 4,
  parameter int               MAX_BURST = 4,
  parameter logic [CMD_W-1:0] IDLE_CMD  = dut_bus_pkg::IDLE_CMD
) (
  input  logic              clk,
  input  logic              rst,
  dut_bus_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t inc_mod(idx_t v);
    return (v == idx_t'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  arb_state_e          state_q,    state_d;
  logic [NUM_REQ-1:0]  gnt_q,      gnt_d;
  idx_t                owner_q,    owner_d;
  idx_t                rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                valid_q,    valid_d;
  logic [CMD_W-1:0]    cmd_q,      cmd_d;
  logic [ADR_W-1:0]    adr_q,      adr_d;
  logic [DATA_W-1:0]   data_q,     data_d;

  logic [CMD_W-1:0]    req_cmd  [NUM_REQ];
  logic [ADR_W-1:0]    req_adr  [NUM_REQ];
  logic [DATA_W-1:0]   req_data [NUM_REQ];

  logic                beat;
  idx_t                pick_start;
  idx_t                pick_idx;
  logic                pick_found;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_cmd[k]  = bus.cmd_i[k*CMD_W +: CMD_W];
    assign req_adr[k]  = bus.adr_i[k*ADR_W +: ADR_W];
    assign req_data[k] = bus.data_i[k*DATA_W +: DATA_W];
  end

  assign beat = (state_q == ARB_OWNED) && bus.req_i[owner_q];

  // An owner is checked last by starting one past it; idle searches from rr_ptr.
  assign pick_start = (state_q == ARB_OWNED) ? inc_mod(owner_q) : rr_ptr_q;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req_i   (bus.req_i),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = 1'b0;
    cmd_d      = IDLE_CMD;
    adr_d      = adr_q;
    data_d     = data_q;

    if (beat) begin
      valid_d = 1'b1;
      cmd_d   = req_cmd[owner_q];
      adr_d   = req_adr[owner_q];
      data_d  = req_data[owner_q];
    end

    // A capped lock with no competitor falls through to the search, which
    // lands back on the owner and restarts its count.
    if (beat && bus.lock_i[owner_q] && (beat_cnt_q < CNT_W'(MAX_BURST - 1))) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end else if (pick_found) begin
      state_d    = ARB_OWNED;
      gnt_d      = NUM_REQ'(1) << pick_idx;
      owner_d    = pick_idx;
      beat_cnt_d = '0;
      rr_ptr_d   = inc_mod(pick_idx);
    end else begin
      state_d    = ARB_IDLE;
      gnt_d      = '0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      cmd_q      <= IDLE_CMD;
      adr_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      cmd_q      <= cmd_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.owner_o = owner_q;
  assign bus.valid_o = valid_q;
  assign bus.cmd_o   = cmd_q;
  assign bus.adr_o   = adr_q;
  assign bus.data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_dut_bus_arbiter.sv
// ============================================================================
//  tb_dut_bus_arbiter
//  Vector table, reset corner case and random traffic against a reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dut_bus_arbiter;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  logic clk;
  logic rst;

  dut_bus_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  dut_bus_arbiter #(
    .NUM_REQ   (NREQ),
    .MAX_BURST (MAXB),
    .IDLE_CMD  (4'h0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner as an integer (-1 = nobody), plain counters.
  int         m_own;
  int         m_cnt;
  int         m_rr;
  logic       m_valid;
  logic [3:0] m_cmd, m_adr, m_data;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] cmd;
    logic [3:0] adr;
    logic [3:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_rr = 0;
    m_valid = 1'b0; m_cmd = 4'h0; m_adr = 4'h0; m_data = 4'h0;
  endtask

  task automatic model_step();
    int  k;
    int  start;
    int  w;
    bit  bt;
    k  = m_own;
    bt = (k >= 0) && bus.req_i[k];
    if (bt) begin
      m_valid = 1'b1;
      m_cmd   = bus.cmd_i[4*k +: 4];
      m_adr   = bus.adr_i[4*k +: 4];
      m_data  = bus.data_i[4*k +: 4];
    end else begin
      m_valid = 1'b0;
      m_cmd   = 4'h0;
    end
    if (bt && bus.lock_i[k] && m_cnt < MAXB - 1) begin
      m_cnt++;
    end else begin
      start = (k >= 0) ? (k + 1) % NREQ : m_rr;
      w = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (w < 0 && bus.req_i[(start + i) % NREQ]) w = (start + i) % NREQ;
      end
      m_own = w;
      m_cnt = 0;
      if (w >= 0) m_rr = (w + 1) % NREQ;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic model_cmp(input string tag);
    logic [31:0] eg;
    eg = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
    check({tag, ".gnt"},   32'(bus.gnt_o),   eg);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(m_valid));
    check({tag, ".cmd"},   32'(bus.cmd_o),   32'(m_cmd));
    check({tag, ".adr"},   32'(bus.adr_o),   32'(m_adr));
    check({tag, ".data"},  32'(bus.data_o),  32'(m_data));
    if (m_own >= 0) check({tag, ".owner"}, 32'(bus.owner_o), 32'(m_own));
  endtask

  task automatic add(input logic [3:0] rq, input logic [3:0] lk, input logic [3:0] g,
                     input logic v, input logic [3:0] c, input logic [3:0] a,
                     input logic [3:0] d);
    vec_t r;
    r.req = rq; r.lock = lk; r.gnt = g; r.valid = v; r.cmd = c; r.adr = a; r.data = d;
    vecs.push_back(r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".gnt"},   32'(bus.gnt_o),   32'd0);
    check({tag, ".owner"}, 32'(bus.owner_o), 32'd0);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, ".cmd"},   32'(bus.cmd_o),   32'd0);
    check({tag, ".adr"},   32'(bus.adr_o),   32'd0);
    check({tag, ".data"},  32'(bus.data_o),  32'd0);
  endtask

  initial begin
    // Requester k offers cmd=3+k, adr=5+k, data=9+k.
    // Fairness from rr_ptr=0, then 8 round-robin beats.
    add(4'hF, 4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 4'h0);
    add(4'hF, 4'h0, 4'h2, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'hF, 4'h0, 4'h4, 1'b1, 4'h4, 4'h6, 4'hA);
    add(4'hF, 4'h0, 4'h8, 1'b1, 4'h5, 4'h7, 4'hB);
    add(4'hF, 4'h0, 4'h1, 1'b1, 4'h6, 4'h8, 4'hC);
    add(4'hF, 4'h0, 4'h2, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'hF, 4'h0, 4'h4, 1'b1, 4'h4, 4'h6, 4'hA);
    add(4'hF, 4'h0, 4'h8, 1'b1, 4'h5, 4'h7, 4'hB);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h7, 4'hB);
    // Burst cap: owner 0 locked for 4 beats, then 1, then back to 0.
    add(4'h3, 4'h1, 4'h1, 1'b0, 4'h0, 4'h7, 4'hB);
    for (int i = 0; i < 3; i++) add(4'h3, 4'h1, 4'h1, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h3, 4'h1, 4'h2, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h3, 4'h1, 4'h1, 1'b1, 4'h4, 4'h6, 4'hA);
    add(4'h3, 4'h1, 4'h1, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h5, 4'h9);
    // Lock with no competitor: 10 beats with no gap at the cap.
    add(4'h1, 4'h1, 4'h1, 1'b0, 4'h0, 4'h5, 4'h9);
    for (int i = 0; i < 10; i++) add(4'h1, 4'h1, 4'h1, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h5, 4'h9);
    // Owner 2 drops while 3 waits.
    add(4'hC, 4'h0, 4'h4, 1'b0, 4'h0, 4'h5, 4'h9);
    add(4'h8, 4'h0, 4'h8, 1'b0, 4'h0, 4'h5, 4'h9);
    add(4'h8, 4'h0, 4'h8, 1'b1, 4'h6, 4'h8, 4'hC);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h8, 4'hC);
    // Single persistent requester.
    add(4'h1, 4'h0, 4'h1, 1'b0, 4'h0, 4'h8, 4'hC);
    for (int i = 0; i < 3; i++) add(4'h1, 4'h0, 4'h1, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h5, 4'h9);
    // Lock held by a non-owner has no effect.
    add(4'h3, 4'h1, 4'h2, 1'b0, 4'h0, 4'h5, 4'h9);
    add(4'h3, 4'h1, 4'h1, 1'b1, 4'h4, 4'h6, 4'hA);
    add(4'h3, 4'h1, 4'h1, 1'b1, 4'h3, 4'h5, 4'h9);
    add(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h5, 4'h9);

    rst        = 1'b1;
    bus.req_i  = 4'h0;
    bus.lock_i = 4'h0;
    bus.cmd_i  = 16'h6543;
    bus.adr_i  = 16'h8765;
    bus.data_i = 16'hCBA9;
    model_reset();
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.req_i  = vecs[i].req;
      bus.lock_i = vecs[i].lock;
      tick();
      check($sformatf("tbl[%0d].gnt", i),   32'(bus.gnt_o),   32'(vecs[i].gnt));
      check($sformatf("tbl[%0d].valid", i), 32'(bus.valid_o), 32'(vecs[i].valid));
      check($sformatf("tbl[%0d].cmd", i),   32'(bus.cmd_o),   32'(vecs[i].cmd));
      check($sformatf("tbl[%0d].adr", i),   32'(bus.adr_o),   32'(vecs[i].adr));
      check($sformatf("tbl[%0d].data", i),  32'(bus.data_o),  32'(vecs[i].data));
      model_cmp($sformatf("tblm[%0d]", i));
    end

    // Reset in the middle of a locked burst (rr_ptr is 1 beforehand).
    bus.req_i  = 4'h1;
    bus.lock_i = 4'h1;
    tick(); model_cmp("pre_rst0");
    tick(); model_cmp("pre_rst1");
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    bus.req_i  = 4'hF;
    bus.lock_i = 4'h0;
    tick(); model_cmp("in_rst");
    rst = 1'b0;
    tick();
    check("rst_rr_ptr.gnt",    32'(bus.gnt_o),   32'd1);
    check("rst_no_beat.valid", 32'(bus.valid_o), 32'd0);
    model_cmp("post_rst");

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req_i = 4'($urandom);
      bus.lock_i = 4'($urandom);
      bus.cmd_i  = 16'($urandom);
      bus.adr_i  = 16'($urandom);
      bus.data_i = 16'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      model_cmp($sformatf("rnd[%0d]", c));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
